// File: rtl/sa_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Shared types and default dimensions for the systolic-array
//               input/weight sequencer and its result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

  // Sequencer job phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } sa_state_t;

  // Default element widths and array geometry
  localparam int unsigned c_input_width    = 16;
  localparam int unsigned c_weight_width   = 16;
  localparam int unsigned c_psum_width     = 32;
  localparam int unsigned c_array_height   = 4;
  localparam int unsigned c_array_width    = 4;
  localparam int unsigned c_res_depth      = 4;
  localparam int unsigned c_num_vecs_width = 16;

endpackage
`default_nettype wire

// File: rtl/sa_is_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sa_is_sequencer_if
// Description : Job control, input/weight/result handshakes and array-facing
//               signals of the sequencer. slave = sequencer side,
//               master = job source / array / result consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sa_is_sequencer_if #(
  parameter int unsigned INPUT_WIDTH  = sa_pkg::c_input_width,
  parameter int unsigned WEIGHT_WIDTH = sa_pkg::c_weight_width,
  parameter int unsigned PSUM_WIDTH   = sa_pkg::c_psum_width,
  parameter int unsigned ARRAY_HEIGHT = sa_pkg::c_array_height,
  parameter int unsigned ARRAY_WIDTH  = sa_pkg::c_array_width
) ();
  import sa_pkg::*;

  // Job control
  logic                                          start;
  logic [c_num_vecs_width-1:0]                   num_vecs;
  logic                                          busy;
  logic                                          done;
  // Input-vector load
  logic                                          in_valid;
  logic                                          in_ready;
  logic [ARRAY_HEIGHT-1:0][INPUT_WIDTH-1:0]      in_data;
  // Weight-vector stream
  logic                                          w_valid;
  logic                                          w_ready;
  logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0]      w_data;
  // Array side
  logic                                          arr_input_en;
  logic                                          arr_process_en;
  logic [ARRAY_HEIGHT-1:0][INPUT_WIDTH-1:0]      arr_input_in;
  logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0]      arr_weight_in;
  logic [ARRAY_HEIGHT-1:0][PSUM_WIDTH-1:0]       arr_psum_out;
  // Result stream
  logic                                          res_valid;
  logic                                          res_ready;
  logic [ARRAY_HEIGHT-1:0][PSUM_WIDTH-1:0]       res_data;

  modport slave (
    input  start, num_vecs, in_valid, in_data, w_valid, w_data,
           arr_psum_out, res_ready,
    output busy, done, in_ready, w_ready, arr_input_en, arr_process_en,
           arr_input_in, arr_weight_in, res_valid, res_data
  );

  modport master (
    output start, num_vecs, in_valid, in_data, w_valid, w_data,
           arr_psum_out, res_ready,
    input  busy, done, in_ready, w_ready, arr_input_en, arr_process_en,
           arr_input_in, arr_weight_in, res_valid, res_data
  );

endinterface
`default_nettype wire

// File: rtl/sa_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sa_result_fifo
// Description : Synchronous FIFO for array result vectors. DEPTH must be a
//               power of two (>= 2); pointers carry one wrap bit so full and
//               empty are distinguished without a counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_fifo #(
  parameter int unsigned DATA_WIDTH = sa_pkg::c_array_height * sa_pkg::c_psum_width,
  parameter int unsigned DEPTH      = sa_pkg::c_res_depth
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  push,
  input  wire [DATA_WIDTH-1:0] push_data,
  input  wire                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                 full,
  output logic                 empty
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]         r_wr_ptr;
  logic [ADDR_W:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    w_do_push;
  logic                    w_do_pop;

  assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                 (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  // A pop frees the head slot in the same edge, so a push at full is safe then
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  // Head is forced to zero when empty so stale entries never appear outside
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Pointer update; reset discards any queued results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the write pointer passes them
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sa_is_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sa_is_sequencer
// Description : Input-stationary systolic-array sequencer. Loads one input
//               vector per column, streams num_vecs weight vectors, tracks
//               each through the array with a 1-bit tag pipe and collects the
//               tagged results into a FIFO, throttling the array when full.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_is_sequencer #(
  parameter int unsigned INPUT_WIDTH  = sa_pkg::c_input_width,
  parameter int unsigned WEIGHT_WIDTH = sa_pkg::c_weight_width,
  parameter int unsigned PSUM_WIDTH   = sa_pkg::c_psum_width,
  parameter int unsigned ARRAY_HEIGHT = sa_pkg::c_array_height,
  parameter int unsigned ARRAY_WIDTH  = sa_pkg::c_array_width,
  parameter int unsigned PIPE_LATENCY = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int unsigned RES_DEPTH    = sa_pkg::c_res_depth
) (
  input  wire              clk,
  input  wire              rst_n,
  sa_is_sequencer_if.slave bus
);
  import sa_pkg::*;

  localparam int unsigned LOAD_CW = $clog2(ARRAY_WIDTH + 1);
  localparam int unsigned RES_W   = ARRAY_HEIGHT * PSUM_WIDTH;

  sa_state_t                                 r_state;
  sa_state_t                                 w_next_state;
  logic [LOAD_CW-1:0]                        r_load_cnt;
  logic [c_num_vecs_width-1:0]               r_num_vecs;
  logic [c_num_vecs_width-1:0]               r_w_cnt;
  logic [c_num_vecs_width-1:0]               r_pop_cnt;
  logic [PIPE_LATENCY-1:0]                   r_tag;

  logic [ARRAY_HEIGHT-1:0][INPUT_WIDTH-1:0]  w_in_data;
  logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0]  w_w_data;
  logic [ARRAY_HEIGHT-1:0][PSUM_WIDTH-1:0]   w_psum;
  logic [RES_W-1:0]                          w_psum_flat;
  logic [RES_W-1:0]                          w_head;

  logic w_in_hs;
  logic w_load_last;
  logic w_process_en;
  logic w_more;
  logic w_w_ready;
  logic w_w_hs;
  logic w_stream_last;
  logic w_drain_last;
  logic w_push;
  logic w_pop;
  logic w_fifo_full;
  logic w_fifo_empty;

  assign w_in_data   = bus.in_data;
  assign w_w_data    = bus.w_data;
  assign w_psum      = bus.arr_psum_out;
  assign w_psum_flat = w_psum;

  // Handshake qualifiers shared by next-state, counters and outputs
  assign w_in_hs      = (r_state == ST_LOAD) && bus.in_valid;
  assign w_load_last  = (r_load_cnt == LOAD_CW'(ARRAY_WIDTH - 1));
  // The array only advances while the FIFO has room for whatever emerges
  assign w_process_en = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) && !w_fifo_full;
  // Never accept more weights than the job asked for (covers num_vecs = 0)
  assign w_more       = (r_w_cnt != r_num_vecs);
  assign w_w_ready    = (r_state == ST_STREAM) && w_process_en && w_more;
  assign w_w_hs       = w_w_ready && bus.w_valid;
  assign w_pop        = !w_fifo_empty && bus.res_ready;
  assign w_push       = w_process_en && r_tag[PIPE_LATENCY-1];

  assign w_stream_last = (({1'b0, r_w_cnt} + 17'(w_w_hs)) == {1'b0, r_num_vecs});
  // Pushes equal accepted weights, so once every result is popped the FIFO
  // is necessarily empty; the tag check guards against in-flight work.
  assign w_drain_last  = (({1'b0, r_pop_cnt} + 17'(w_pop)) == {1'b0, r_num_vecs}) &&
                         (r_tag == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start)              w_next_state = ST_LOAD;
      ST_LOAD:   if (w_in_hs && w_load_last) w_next_state = ST_STREAM;
      ST_STREAM: if (w_stream_last)          w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_drain_last)           w_next_state = ST_IDLE;
      default:                               w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from current state and handshake qualifiers
  always_comb begin
    bus.busy           = (r_state != ST_IDLE);
    bus.done           = (r_state == ST_DRAIN) && w_drain_last;
    bus.in_ready       = (r_state == ST_LOAD);
    bus.arr_input_en   = w_in_hs;
    bus.arr_input_in   = (r_state == ST_LOAD) ? w_in_data : '0;
    bus.arr_process_en = w_process_en;
    bus.w_ready        = w_w_ready;
    bus.arr_weight_in  = w_w_hs ? w_w_data : '0;
    bus.res_valid      = !w_fifo_empty;
    bus.res_data       = w_head;
  end

  // Job counters; num_vecs is captured once so later changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt <= '0;
      r_num_vecs <= '0;
      r_w_cnt    <= '0;
      r_pop_cnt  <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_load_cnt <= '0;
      r_num_vecs <= bus.num_vecs;
      r_w_cnt    <= '0;
      r_pop_cnt  <= '0;
    end else begin
      if (w_in_hs) r_load_cnt <= r_load_cnt + 1'b1;
      if (w_w_hs)  r_w_cnt    <= r_w_cnt + 1'b1;
      if (w_pop)   r_pop_cnt  <= r_pop_cnt + 1'b1;
    end
  end

  // Tag pipe mirrors the array latency: a 1 marks a real weight, 0 a bubble
  generate
    if (PIPE_LATENCY == 1) begin : g_tag_single
      // Single-stage tag register, frozen with the array
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_tag <= '0;
        else if (w_process_en) r_tag <= w_w_hs;
      end
    end else begin : g_tag_multi
      // Multi-stage tag shift, frozen with the array
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_tag <= '0;
        else if (w_process_en) r_tag <= {r_tag[PIPE_LATENCY-2:0], w_w_hs};
      end
    end
  endgenerate

  sa_result_fifo #(
    .DATA_WIDTH (RES_W),
    .DEPTH      (RES_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_psum_flat),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

endmodule
`default_nettype wire
